// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a full-adder chain
// with a registered carry, start/busy/done handshake, back-to-back capable.

module serial_add_sub_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);
  localparam int STEPS = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_add_sub: WIDTH must be >= 1, DIGIT >= 1 and WIDTH a multiple of DIGIT");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Digit-wide ripple chain; the only path between digits is carry_q.
  logic [DIGIT:0]         chain;
  logic [DIGIT-1:0]       dsum;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_shift;
  logic [WIDTH-1:0]       b_eff;

  assign chain[0] = carry_q;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_lane
    serial_add_sub_fa u_fa (
      .a  (opa_q[gi]),
      .b  (opb_q[gi]),
      .ci (chain[gi]),
      .s  (dsum[gi]),
      .co (chain[gi+1])
    );
  end

  // New digit enters at the top, so after STEPS shifts the LSB digit sits at bit 0.
  assign res_cat   = {dsum, res_q};
  assign res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign b_eff     = sub ? ~b : b;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b_eff;
          carry_d = sub;
          cnt_d   = '0;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b_eff[WIDTH-1];
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        carry_d = chain[DIGIT];
        res_d   = res_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = res_shift;
          cout_d  = chain[DIGIT];
          ovf_d   = (amsb_q == bmsb_q) && (res_shift[WIDTH-1] != amsb_q);
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and swept checks of serial_add_sub for DIGIT = 1, 2, 4, 8 at WIDTH = 8.

module tb_serial_add_sub;
  logic       clk = 1'b0;
  logic       rst;
  logic       sub;
  logic [7:0] a, b;
  logic       start_w [4];
  logic [7:0] sum_w   [4];
  logic       cout_w  [4];
  logic       ovf_w   [4];
  logic       busy_w  [4];
  logic       done_w  [4];

  int ncmp = 0;
  int nerr = 0;

  // Index 0..3 carries DIGIT 1, 2, 4, 8.
  localparam int ST [4] = '{8, 4, 2, 1};

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_w[0]), .sub(sub), .a(a), .b(b),
    .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  serial_add_sub #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start_w[1]), .sub(sub), .a(a), .b(b),
    .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start_w[2]), .sub(sub), .a(a), .b(b),
    .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  serial_add_sub #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start_w[3]), .sub(sub), .a(a), .b(b),
    .sum(sum_w[3]), .cout(cout_w[3]), .ovf(ovf_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input int d, input logic s, input logic [7:0] aa, input logic [7:0] bb);
    a = aa; b = bb; sub = s; start_w[d] = 1'b1;
    tick();
    start_w[d] = 1'b0;
  endtask

  // {cout, ovf, sum} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic s, input logic [7:0] aa, input logic [7:0] bb);
    logic [7:0] bp;
    logic [8:0] t;
    logic       o;
    bp = s ? ~bb : bb;
    t  = {1'b0, aa} + {1'b0, bp} + {8'd0, s};
    o  = (aa[7] == bp[7]) && (t[7] != aa[7]);
    return {t[8], o, t[7:0]};
  endfunction

  task automatic sweep_case(input logic s, input logic [7:0] aa, input logic [7:0] bb);
    logic [9:0] m;
    m = model(s, aa, bb);
    a = aa; b = bb; sub = s;
    for (int d = 0; d < 4; d++) start_w[d] = 1'b1;
    tick();
    for (int d = 0; d < 4; d++) start_w[d] = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      for (int d = 0; d < 4; d++)
        if (t == ST[d])
          chk($sformatf("sweep d%0d s%0d %02h,%02h", d, s, aa, bb),
              {21'd0, done_w[d], cout_w[d], ovf_w[d], sum_w[d]}, {21'd0, 1'b1, m});
    end
  endtask

  initial begin
    logic [7:0] corners [5];
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    rst = 1'b1; sub = 1'b0; a = '0; b = '0;
    for (int d = 0; d < 4; d++) start_w[d] = 1'b0;
    tick(); tick();
    for (int d = 0; d < 4; d++)
      chk($sformatf("reset d%0d", d),
          {20'd0, sum_w[d], cout_w[d], ovf_w[d], busy_w[d], done_w[d]}, 32'd0);
    rst = 1'b0;
    tick();

    // 0x5A + 0x3C, one bit per cycle: 8 busy cycles then a single done.
    launch(0, 1'b0, 8'h5A, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("add busy c%0d", i), {30'd0, busy_w[0], done_w[0]}, 32'h2);
      tick();
    end
    chk("add done", {30'd0, busy_w[0], done_w[0]}, 32'h1);
    chk("add 5a+3c", {22'd0, cout_w[0], ovf_w[0], sum_w[0]}, {22'd0, 1'b0, 1'b1, 8'h96});
    tick();
    chk("add done drops", {30'd0, busy_w[0], done_w[0]}, 32'h0);

    launch(0, 1'b1, 8'h10, 8'h20);
    repeat (8) tick();
    chk("sub 10-20", {21'd0, done_w[0], cout_w[0], ovf_w[0], sum_w[0]}, {21'd0, 1'b1, 1'b0, 1'b0, 8'hF0});
    tick();
    launch(0, 1'b1, 8'h80, 8'h01);
    repeat (8) tick();
    chk("sub 80-01", {21'd0, done_w[0], cout_w[0], ovf_w[0], sum_w[0]}, {21'd0, 1'b1, 1'b1, 1'b1, 8'h7F});
    tick();

    // DIGIT=4: two compute cycles.
    launch(2, 1'b0, 8'hFF, 8'h01);
    tick();
    chk("d4 not yet", {31'd0, done_w[2]}, 32'h0);
    tick();
    chk("d4 ff+01", {21'd0, done_w[2], cout_w[2], ovf_w[2], sum_w[2]}, {21'd0, 1'b1, 1'b1, 1'b0, 8'h00});
    tick();

    // start held high, operands scrambled during RUN.
    a = 8'h11; b = 8'h22; sub = 1'b0; start_w[0] = 1'b1;
    tick();
    chk("b2b hold sum", {24'd0, sum_w[0]}, 32'h7F);
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); tick();
    end
    chk("b2b op1", {21'd0, done_w[0], cout_w[0], ovf_w[0], sum_w[0]}, {21'd0, 1'b1, 1'b0, 1'b0, 8'h33});
    a = 8'hF0; b = 8'h20; sub = 1'b1;
    tick();
    chk("b2b op2 busy", {30'd0, busy_w[0], done_w[0]}, 32'h2);
    chk("b2b op2 hold", {24'd0, sum_w[0]}, 32'h33);
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); tick();
    end
    chk("b2b op2", {21'd0, done_w[0], cout_w[0], ovf_w[0], sum_w[0]}, {21'd0, 1'b1, 1'b1, 1'b0, 8'hD0});
    a = 8'h7F; b = 8'h01; sub = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); tick();
    end
    chk("b2b op3", {21'd0, done_w[0], cout_w[0], ovf_w[0], sum_w[0]}, {21'd0, 1'b1, 1'b0, 1'b1, 8'h80});
    start_w[0] = 1'b0;
    tick();
    chk("b2b idle", {30'd0, busy_w[0], done_w[0]}, 32'h0);

    // Asynchronous abort in the third RUN cycle.
    launch(0, 1'b0, 8'h5A, 8'h3C);
    tick(); tick();
    #1 rst = 1'b1;
    #1;
    chk("abort outputs", {20'd0, sum_w[0], cout_w[0], ovf_w[0], busy_w[0], done_w[0]}, 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("abort quiet c%0d", i), {30'd0, busy_w[0], done_w[0]}, 32'h0);
    end
    launch(0, 1'b0, 8'h5A, 8'h3C);
    repeat (8) tick();
    chk("after abort", {21'd0, done_w[0], cout_w[0], ovf_w[0], sum_w[0]}, {21'd0, 1'b1, 1'b0, 1'b1, 8'h96});
    tick();

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          sweep_case(1'(s), corners[i], corners[j]);
    for (int n = 0; n < 1000; n++) begin
      sweep_case(1'b0, 8'($urandom), 8'($urandom));
      sweep_case(1'b1, 8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
